pulse_spacer: RTL and testbench
===============================

PULSE_SPACER -- requirements
Module: pulse_spacer

Interface
REQ-001 Parameter GAP, default 140, minimum clock cycles between consecutive PULSE_OUT rising edges; legal range 2..65535.
REQ-002 Parameter CNT_WIDTH, default 8, width of the pending-event counter.
REQ-003 Port CLK  input  1  single clock; all logic on its rising edge.
REQ-004 Port RST  input  1  synchronous, active-high reset.
REQ-005 Port PULSE_IN  input  1  event request; each high cycle is one event.
REQ-006 Port PULSE_OUT  output  1  registered one-cycle pulse, spaced for a downstream counter-based CDC pulse synchronizer.
REQ-007 Port PENDING  output  CNT_WIDTH  number of accepted events not yet emitted.
REQ-008 Port BUSY  output  1  high when the spacing state is GAP or PENDING != 0.
REQ-009 Port OVERFLOW  output  1  sticky flag: at least one event was dropped.
REQ-010 Port CLR_OVF  input  1  synchronous clear of OVERFLOW.

Function
REQ-011 The block SHALL have two states: IDLE (emission allowed) and GAP (spacing interval running).
REQ-012 An emit SHALL occur in any cycle where state is IDLE and (PENDING != 0 or PULSE_IN = 1); PULSE_OUT SHALL be high in the following cycle only.
REQ-013 Latency: PULSE_IN high at cycle n, state IDLE, PENDING = 0 -> PULSE_OUT high at n+1; that event is never counted in PENDING.
REQ-014 On emit, state SHALL go to GAP with a 16-bit gap counter loaded so that the next emit cannot occur before cycle (emit cycle + GAP); state SHALL return to IDLE at exactly that cycle.
REQ-015 Back-to-back queued events SHALL produce PULSE_OUT rising edges exactly GAP cycles apart.
REQ-016 PENDING next value SHALL be PENDING + accept - (emit AND PENDING != 0), where accept = PULSE_IN AND NOT (direct emit with PENDING = 0).
REQ-017 PENDING SHALL saturate at 2^CNT_WIDTH-1; an accept while PENDING is at maximum and no decrement occurs in the same cycle SHALL be dropped and SHALL set OVERFLOW.
REQ-018 Accept and decrement in the same cycle at maximum SHALL leave PENDING at maximum with no overflow.
REQ-019 PULSE_IN held high for k cycles SHALL count as k events.
REQ-020 OVERFLOW SHALL stay set until CLR_OVF or RST; CLR_OVF and a new drop in the same cycle SHALL leave OVERFLOW set.
REQ-021 PENDING, BUSY and OVERFLOW SHALL be registered or derived only from registered state, with no combinational path from PULSE_IN to any output.

Reset
REQ-022 While RST is high: PULSE_OUT = 0, PENDING = 0, OVERFLOW = 0, BUSY = 0, state IDLE, gap counter 0; PULSE_IN is ignored.
REQ-023 RST asserted during GAP or with events pending SHALL discard all pending events; the first PULSE_IN after RST deasserts SHALL emit with REQ-013 latency.

Verification
REQ-024 Single PULSE_IN at cycle 10 after reset -> PULSE_OUT high only at cycle 11; PENDING stays 0; BUSY high cycles 11..149 (GAP=140).
REQ-025 PULSE_IN high 3 consecutive cycles starting at cycle 10 -> PULSE_OUT at 11, 151, 291; PENDING reads 1, 2, then decrements at each emit; BUSY low from cycle 291+140-1 onward.
REQ-026 CNT_WIDTH=2, PULSE_IN high 6 cycles starting at cycle 10 -> first event emitted directly, PENDING saturates at 3, 2 events dropped, OVERFLOW=1; total PULSE_OUT count 4.
REQ-027 OVERFLOW set, CLR_OVF pulsed one cycle with no new drop -> OVERFLOW 0 next cycle; repeat with a simultaneous drop -> OVERFLOW remains 1.
REQ-028 RST pulsed one cycle 50 cycles into a GAP with PENDING=2 -> outputs zero next cycle; subsequent PULSE_IN at cycle r -> PULSE_OUT at r+1.
REQ-029 Integration check: PULSE_SPACER output into the counter-based CDC pulse synchronizer, random PULSE_IN bursts -> destination-domain pulse count equals source emit count (no coalescing) for GAP=140.

Source files
------------

// File: rtl/pulse_spacer.sv
// pulse_spacer: queues single-cycle events and re-emits them at least
// GAP cycles apart so a counter-based pulse synchronizer never coalesces.
module pulse_spacer #(
  parameter int GAP       = 140,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PULSE_IN,
  input  logic                 CLR_OVF,
  output logic                 PULSE_OUT,
  output logic [CNT_WIDTH-1:0] PENDING,
  output logic                 BUSY,
  output logic                 OVERFLOW
);

  typedef enum logic {S_IDLE, S_GAP} state_t;

  localparam logic [15:0] GAP_LOAD = 16'(GAP - 1);
  localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] PEND_ONE = CNT_WIDTH'(1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] gap_cnt;
  logic        has_pend;
  logic        emit;
  logic        dec;
  logic        accept;
  logic        drop;
  logic        inc;

  // A direct emit with nothing queued consumes PULSE_IN itself.
  always_comb begin
    has_pend = (PENDING != '0);
    emit     = (state == S_IDLE) && (has_pend || PULSE_IN);
    dec      = emit && has_pend;
    accept   = PULSE_IN && !(emit && !has_pend);
    drop     = accept && (PENDING == PEND_MAX) && !dec;
    inc      = accept && !drop;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (emit) state_nxt = S_GAP;
      S_GAP:  if (gap_cnt <= 16'd1) state_nxt = S_IDLE;
    endcase
  end

  // Counter runs GAP-1 cycles in S_GAP, so IDLE returns at emit+GAP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PULSE_OUT <= 1'b0;
      gap_cnt   <= '0;
      PENDING   <= '0;
      OVERFLOW  <= 1'b0;
    end else begin
      PULSE_OUT <= emit;
      if (emit)
        gap_cnt <= GAP_LOAD;
      else if (state == S_GAP)
        gap_cnt <= gap_cnt - 16'd1;
      if (inc && !dec)
        PENDING <= PENDING + PEND_ONE;
      else if (dec && !inc)
        PENDING <= PENDING - PEND_ONE;
      if (drop)
        OVERFLOW <= 1'b1;
      else if (CLR_OVF)
        OVERFLOW <= 1'b0;
    end
  end

  always_comb begin
    BUSY = (state == S_GAP) || (PENDING != '0);
  end

endmodule

// File: tb/tb_pulse_spacer.sv
// tb_pulse_spacer: directed checks of spacing, queueing, overflow and
// reset, plus a random burst run through a toggle synchronizer model.
module tb_pulse_spacer;

  logic       CLK = 1'b0;
  logic       dclk = 1'b0;
  logic       RST = 1'b1;
  logic       CLR_OVF = 1'b0;
  logic       pin0 = 1'b0;
  logic       pin1 = 1'b0;
  logic       out0, busy0, ovf0;
  logic       out1, busy1, ovf1;
  logic [7:0] pend0;
  logic [1:0] pend1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int np1 = 0;
  int q0[$];

  logic       tgl = 1'b0;
  logic [2:0] dsync = 3'b000;
  int         dcnt = 0;

  always #5 CLK = ~CLK;
  always #13 dclk = ~dclk;

  pulse_spacer #(.GAP(140), .CNT_WIDTH(8)) u0 (
    .CLK(CLK), .RST(RST), .PULSE_IN(pin0), .CLR_OVF(CLR_OVF),
    .PULSE_OUT(out0), .PENDING(pend0), .BUSY(busy0), .OVERFLOW(ovf0)
  );

  pulse_spacer #(.GAP(140), .CNT_WIDTH(2)) u1 (
    .CLK(CLK), .RST(RST), .PULSE_IN(pin1), .CLR_OVF(CLR_OVF),
    .PULSE_OUT(out1), .PENDING(pend1), .BUSY(busy1), .OVERFLOW(ovf1)
  );

  // Destination side: toggle, 2-flop sync, edge count.
  always @(posedge CLK) if (out0) tgl <= ~tgl;

  always @(posedge dclk) begin
    dsync <= {dsync[1:0], tgl};
    if (dsync[2] ^ dsync[1]) dcnt <= dcnt + 1;
  end

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (out0) q0.push_back(cyc);
    if (out1) np1++;
  endtask

  task automatic run_to(int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    pin0 = 1'b1;
    pin1 = 1'b1;
    step();
    step();
    check("rst_out", int'(out0), 0);
    check("rst_pend", int'(pend0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_ovf", int'(ovf0), 0);
    check("rst_pend1", int'(pend1), 0);
    pin0 = 1'b0;
    pin1 = 1'b0;
    RST = 1'b0;
    step();
    cyc = 0;
    q0.delete();
    np1 = 0;
  endtask

  initial begin
    int busy_lo;
    int ev;
    int d0;
    int bad;

    // single event: direct emit, no queueing
    do_reset();
    run_to(10);
    pin0 = 1'b1;
    step();
    pin0 = 1'b0;
    check("a_out", int'(out0), 1);
    check("a_pend", int'(pend0), 0);
    check("a_busy11", int'(busy0), 1);
    busy_lo = 0;
    while (cyc < 149) begin
      step();
      if (!busy0) busy_lo++;
    end
    check("a_busy_hold", busy_lo, 0);
    step();
    check("a_busy150", int'(busy0), 0);
    check("a_npulse", q0.size(), 1);

    // three back-to-back events
    do_reset();
    run_to(10);
    pin0 = 1'b1;
    step();
    step();
    check("b_pend12", int'(pend0), 1);
    step();
    pin0 = 1'b0;
    check("b_pend13", int'(pend0), 2);
    run_to(151);
    check("b_pend151", int'(pend0), 1);
    run_to(291);
    check("b_pend291", int'(pend0), 0);
    run_to(429);
    check("b_busy429", int'(busy0), 1);
    step();
    check("b_busy430", int'(busy0), 0);
    check("b_npulse", q0.size(), 3);
    if (q0.size() == 3) begin
      check("b_t0", q0[0], 11);
      check("b_t1", q0[1], 151);
      check("b_t2", q0[2], 291);
    end

    // saturation and overflow on the 2-bit instance
    do_reset();
    run_to(10);
    pin1 = 1'b1;
    repeat (6) step();
    pin1 = 1'b0;
    check("c_pend_sat", int'(pend1), 3);
    check("c_ovf", int'(ovf1), 1);
    run_to(440);
    check("c_npulse", np1, 4);
    check("c_pend_empty", int'(pend1), 0);
    check("c_ovf_sticky", int'(ovf1), 1);

    CLR_OVF = 1'b1;
    step();
    CLR_OVF = 1'b0;
    check("d_clr", int'(ovf1), 0);
    pin1 = 1'b1;
    repeat (4) step();
    check("d_refill", int'(pend1), 3);
    check("d_reovf", int'(ovf1), 1);
    CLR_OVF = 1'b1;
    step();
    check("d_clr_drop", int'(ovf1), 1);
    pin1 = 1'b0;
    step();
    CLR_OVF = 1'b0;
    check("d_clr2", int'(ovf1), 0);
    check("d_pend_keep", int'(pend1), 3);

    // accept and decrement together at max
    run_to(570);
    pin1 = 1'b1;
    step();
    pin1 = 1'b0;
    check("e_out", int'(out1), 1);
    check("e_pend_max", int'(pend1), 3);
    check("e_no_ovf", int'(ovf1), 0);

    // reset in the middle of a gap with events queued
    do_reset();
    run_to(10);
    pin0 = 1'b1;
    repeat (3) step();
    pin0 = 1'b0;
    check("f_pend2", int'(pend0), 2);
    run_to(61);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("f_rst_out", int'(out0), 0);
    check("f_rst_pend", int'(pend0), 0);
    check("f_rst_busy", int'(busy0), 0);
    run_to(70);
    pin0 = 1'b1;
    step();
    pin0 = 1'b0;
    check("f_relaunch", int'(out0), 1);
    repeat (20) step();

    // random bursts through the synchronizer model
    do_reset();
    repeat (20) step();
    q0.delete();
    d0 = dcnt;
    ev = 0;
    for (int b = 0; b < 8; b++) begin
      int len;
      int idle;
      len = $urandom_range(1, 4);
      idle = $urandom_range(0, 200);
      pin0 = 1'b1;
      repeat (len) begin
        step();
        ev++;
      end
      pin0 = 1'b0;
      repeat (idle) step();
    end
    for (int i = 0; i < 8000 && busy0; i++) step();
    check("r_drain", int'(busy0), 0);
    repeat (20) step();
    check("r_emits", q0.size(), ev);
    check("r_dst_cnt", dcnt - d0, ev);
    bad = 0;
    for (int i = 1; i < q0.size(); i++)
      if (q0[i] - q0[i-1] < 140) bad++;
    check("r_spacing", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
